// File: rtl/mux_nne1_arb.sv
// N-to-1 channel mux with fixed-select or round-robin arbitration, one output register stage.
// Latency 1 cycle from Valid_in/Gati_in handshake to Dalja/Valid_out; back-to-back with no bubble.
// Backpressure: Ready_out low with a held word deasserts every Gati_in bit. MUX_NNE1_PARITY_EN adds Paritet.
module mux_nne1_arb #(
  parameter int W  = 24,
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [N*W-1:0]  Hyrjet,
  input  logic [N-1:0]    Valid_in,
  output logic [N-1:0]    Gati_in,
  input  logic [SW-1:0]   S,
  input  logic            Modi,
`ifdef MUX_NNE1_PARITY_EN
  output logic            Paritet,
`endif
  output logic [W-1:0]    Dalja,
  output logic            Valid_out,
  input  logic            Ready_out,
  output logic [SW-1:0]   Kanali
);

  // Round-robin pointer: last channel granted in mode 1; search begins one past it.
  logic [SW-1:0] ptr;

  logic          can_load;
  logic [SW-1:0] rr_idx;
  logic          rr_found;
  logic [SW-1:0] sel;
  logic [N-1:0]  grant;
  logic          xfer;
  logic [W-1:0]  sel_dat;

  assign can_load = !Valid_out || Ready_out;

  // Cyclic first-valid search from ptr+1 around to ptr.
  always_comb begin
    int idx;
    rr_idx   = '0;
    rr_found = 1'b0;
    idx      = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!rr_found && Valid_in[idx]) begin
        rr_found = 1'b1;
        rr_idx   = idx[SW-1:0];
      end
    end
  end

  // Grant vector: fixed select offers the slot regardless of Valid_in; round-robin only to a valid channel.
  always_comb begin
    grant = '0;
    sel   = '0;
    if (Modi) begin
      sel = rr_idx;
      if (rr_found) begin
        grant[rr_idx] = 1'b1;
      end
    end else begin
      sel = S;
      if (int'(S) < N) begin
        grant[S] = 1'b1;
      end
    end
    if (!can_load || Reset) begin
      grant = '0;
    end
  end

  assign Gati_in = grant;
  assign xfer    = |(grant & Valid_in);

  // Data mux written as a compare loop so an out-of-range S never indexes past Hyrjet.
  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == SW'(k)) begin
        sel_dat = Hyrjet[k*W +: W];
      end
    end
  end

  // Output register and pointer; reset wins over a same-cycle transfer and drops any held word.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Valid_out <= 1'b0;
      Dalja     <= '0;
      Kanali    <= '0;
      ptr       <= SW'(N - 1);
    end else if (xfer) begin
      Valid_out <= 1'b1;
      Dalja     <= sel_dat;
      Kanali    <= sel;
      if (Modi) begin
        ptr <= sel;
      end
    end else if (Ready_out) begin
      Valid_out <= 1'b0;
    end
  end

`ifdef MUX_NNE1_PARITY_EN
  // Parity travels with the word it describes and holds with it under backpressure.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Paritet <= 1'b0;
    end else if (xfer) begin
      Paritet <= ^sel_dat;
    end
  end
`endif

endmodule

// File: tb/tb_mux_nne1_arb.sv
module tb_mux_nne1_arb;

  localparam int W  = 24;
  localparam int N  = 4;
  localparam int SW = 2;

  logic            Clock;
  logic            Reset;
  logic [N*W-1:0]  Hyrjet;
  logic [N-1:0]    Valid_in;
  logic [N-1:0]    Gati_in;
  logic [SW-1:0]   S;
  logic            Modi;
  logic [W-1:0]    Dalja;
  logic            Valid_out;
  logic            Ready_out;
  logic [SW-1:0]   Kanali;
`ifdef MUX_NNE1_PARITY_EN
  logic            Paritet;
`endif

  logic [W-1:0] ch_dat [N];

  int n_tests = 0;
  int n_fail  = 0;

  mux_nne1_arb #(.W(W), .N(N), .SW(SW)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Hyrjet    (Hyrjet),
    .Valid_in  (Valid_in),
    .Gati_in   (Gati_in),
    .S         (S),
    .Modi      (Modi),
`ifdef MUX_NNE1_PARITY_EN
    .Paritet   (Paritet),
`endif
    .Dalja     (Dalja),
    .Valid_out (Valid_out),
    .Ready_out (Ready_out),
    .Kanali    (Kanali)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_data();
    Hyrjet = {ch_dat[3], ch_dat[2], ch_dat[1], ch_dat[0]};
    #1;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Kanali sequences for the round-robin vectors
  int seq_all [5] = '{0, 1, 2, 3, 0};
  int seq_odd [4] = '{1, 3, 1, 3};

  initial begin
    ch_dat[0] = 24'h111111;
    ch_dat[1] = 24'h222222;
    ch_dat[2] = 24'hA5A5A5;
    ch_dat[3] = 24'h333333;
    Reset     = 1'b1;
    Valid_in  = 4'b1111;
    S         = 2'd0;
    Modi      = 1'b1;
    Ready_out = 1'b1;
    drive_data();
    step();
    step();
    chk("rst_gati", 32'(Gati_in), 32'h0);
    chk("rst_vout", 32'(Valid_out), 32'h0);
    chk("rst_dalja", 32'(Dalja), 32'h0);
    chk("rst_kanali", 32'(Kanali), 32'h0);

    // Fixed select of channel 2
    Reset    = 1'b0;
    Modi     = 1'b0;
    S        = 2'd2;
    Valid_in = 4'b0100;
    drive_data();
    chk("m0_gati", 32'(Gati_in), 32'h4);
    step();
    chk("m0_dalja", 32'(Dalja), 32'hA5A5A5);
    chk("m0_kanali", 32'(Kanali), 32'd2);
    chk("m0_vout", 32'(Valid_out), 32'h1);

    // Fixed select offers the slot even to an idle channel; nothing moves
    S        = 2'd1;
    Valid_in = 4'b0100;
    drive_data();
    chk("m0_idle_gati", 32'(Gati_in), 32'h2);
    step();
    chk("m0_idle_vout", 32'(Valid_out), 32'h0);
    chk("m0_idle_dalja", 32'(Dalja), 32'hA5A5A5);

    // Round-robin over all channels; mode-0 transfer left ptr at N-1
    Modi     = 1'b1;
    Valid_in = 4'b1111;
    drive_data();
    chk("rr_first_gati", 32'(Gati_in), 32'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rr_all_kanali%0d", i), 32'(Kanali), 32'(seq_all[i]));
      chk($sformatf("rr_all_dalja%0d", i), 32'(Dalja), 32'(ch_dat[seq_all[i]]));
    end

    // Only odd channels valid
    Valid_in = 4'b1010;
    drive_data();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_odd_gati%0d", i), 32'(Gati_in), 32'(1 << seq_odd[i]));
      step();
      chk($sformatf("rr_odd_kanali%0d", i), 32'(Kanali), 32'(seq_odd[i]));
    end

    // Backpressure hold, then no-bubble release
    Valid_in  = 4'b1111;
    Ready_out = 1'b0;
    drive_data();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_gati%0d", i), 32'(Gati_in), 32'h0);
      step();
      chk($sformatf("bp_kanali%0d", i), 32'(Kanali), 32'd3);
      chk($sformatf("bp_dalja%0d", i), 32'(Dalja), 32'h333333);
      chk($sformatf("bp_vout%0d", i), 32'(Valid_out), 32'h1);
    end
    Ready_out = 1'b1;
    #1;
    chk("rel_gati", 32'(Gati_in), 32'h1);
    step();
    chk("rel_kanali", 32'(Kanali), 32'd0);
    chk("rel_dalja", 32'(Dalja), 32'h111111);
    chk("rel_vout", 32'(Valid_out), 32'h1);

    // Drain with nothing valid
    Valid_in = 4'b0000;
    drive_data();
    chk("drain_gati", 32'(Gati_in), 32'h0);
    step();
    chk("drain_vout", 32'(Valid_out), 32'h0);
    chk("drain_kanali", 32'(Kanali), 32'd0);
    chk("drain_dalja", 32'(Dalja), 32'h111111);

    // Load channel 2, then change mode/select while the word is held
    Valid_in  = 4'b0100;
    Ready_out = 1'b0;
    drive_data();
    chk("ld2_gati", 32'(Gati_in), 32'h4);
    step();
    chk("ld2_kanali", 32'(Kanali), 32'd2);
    Modi     = 1'b0;
    S        = 2'd1;
    Valid_in = 4'b0010;
    drive_data();
    chk("hold_mode_gati", 32'(Gati_in), 32'h0);
    step();
    chk("hold_mode_kanali", 32'(Kanali), 32'd2);
    chk("hold_mode_dalja", 32'(Dalja), 32'hA5A5A5);
    chk("hold_mode_vout", 32'(Valid_out), 32'h1);

    // Reset with a held word and a pending transfer
    Ready_out = 1'b1;
    Reset     = 1'b1;
    #1;
    chk("rst2_gati", 32'(Gati_in), 32'h0);
    step();
    chk("rst2_vout", 32'(Valid_out), 32'h0);
    chk("rst2_dalja", 32'(Dalja), 32'h0);
    chk("rst2_kanali", 32'(Kanali), 32'd0);
    Reset    = 1'b0;
    Modi     = 1'b1;
    Valid_in = 4'b0110;
    drive_data();
    chk("rst2_rr_gati", 32'(Gati_in), 32'h2);
    step();
    chk("rst2_rr_kanali", 32'(Kanali), 32'd1);

`ifdef MUX_NNE1_PARITY_EN
    Modi      = 1'b0;
    S         = 2'd0;
    Valid_in  = 4'b0001;
    ch_dat[0] = 24'h000007;
    drive_data();
    step();
    chk("par_odd", 32'(Paritet), 32'h1);
    ch_dat[0] = 24'h000003;
    drive_data();
    step();
    chk("par_even", 32'(Paritet), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_nne1_arb.md
MUX_NNE1_ARB -- requirements
Module: mux_nne1_arb

Interface
REQ-001 Parameter W, default 24, data width of each channel in bits.
REQ-002 Parameter N, default 4, number of input channels; legal range 2..16.
REQ-003 Parameter SW, default $clog2(N), width of select and channel-index fields.
REQ-004 Clock  input  1  single clock; all state updates on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Hyrjet  input  N*W  packed channel data; channel k at bits [k*W+W-1 : k*W].
REQ-007 Valid_in  input  N  per-channel data-valid.
REQ-008 Gati_in  output  N  per-channel ready; at most one bit high per cycle.
REQ-009 S  input  SW  channel select used in mode 0.
REQ-010 Modi  input  1  0 = fixed select by S; 1 = round-robin arbitration.
REQ-011 Dalja  output  W  registered selected data.
REQ-012 Valid_out  output  1  Dalja holds a valid word.
REQ-013 Ready_out  input  1  downstream accepts Dalja this cycle.
REQ-014 Kanali  output  SW  index of the channel whose word is in Dalja.

Function
REQ-015 can_load = !Valid_out || Ready_out; the block SHALL assert no Gati_in bit when can_load is 0.
REQ-016 A transfer from channel k SHALL occur when Gati_in[k] && Valid_in[k]; Dalja and Kanali load on that edge and Valid_out goes to 1 (latency 1 cycle).
REQ-017 Mode 0: Gati_in[S] = can_load, all other bits 0; S >= N SHALL select no channel (Gati_in = 0).
REQ-018 Mode 1: the grant SHALL go to the first channel with Valid_in high, searching cyclically from ptr+1 through ptr; Gati_in SHALL be one-hot at that channel when can_load, else 0.
REQ-019 Mode 1: ptr SHALL update to the granted channel only on a completed transfer; no valid inputs -> no grant, ptr unchanged.
REQ-020 Mode 0 transfers SHALL NOT modify ptr.
REQ-021 Valid_out && !Ready_out: Dalja, Kanali and Valid_out SHALL hold stable.
REQ-022 Ready_out && no transfer: Valid_out SHALL clear on that edge; Dalja and Kanali retain their last values.
REQ-023 Ready_out && transfer in the same cycle: new word SHALL load with no bubble, Valid_out stays 1.
REQ-024 Modi or S changes SHALL affect only the grant of the current cycle; a held output word is unaffected.
REQ-025 Gati_in SHALL be combinational from Valid_in, S, Modi, ptr and can_load; no combinational path from Hyrjet to any output.

Reset
REQ-026 Reset SHALL set Valid_out = 0, Dalja = 0, Kanali = 0, ptr = N-1 (first round-robin search starts at channel 0).
REQ-027 Reset SHALL take priority over any transfer in the same cycle; Gati_in SHALL be 0 while Reset is high.
REQ-028 Reset mid-stream SHALL drop any held word without presenting it downstream.

Configuration
REQ-029 Macro MUX_NNE1_PARITY_EN defined: extra output Paritet (1 bit) = even parity (XOR-reduce) of the word loaded into Dalja, registered with it, reset to 0, held under REQ-021.
REQ-030 Macro undefined: port Paritet and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 Mode 0, S=2, Valid_in=4'b0100, Hyrjet ch2=24'hA5A5A5, Ready_out=1 -> next cycle Dalja=24'hA5A5A5, Kanali=2, Valid_out=1; Gati_in was 4'b0100.
REQ-032 Mode 1 after reset, Valid_in=4'b1111 held, Ready_out=1 -> Kanali sequence 0,1,2,3,0 on consecutive cycles.
REQ-033 Mode 1, Valid_in=4'b1010, Ready_out=1 -> grants alternate 1,3,1,3; channels 0 and 2 never granted.
REQ-034 Valid_out=1, Ready_out=0 for 3 cycles with Valid_in=4'b1111 -> Gati_in=0, Dalja/Kanali stable; Ready_out=1 -> next word loads in the same edge, no bubble.
REQ-035 Reset asserted while Valid_out=1 and transfer pending -> next cycle Valid_out=0, Dalja=0, Kanali=0; first mode-1 grant afterwards is lowest valid channel.
REQ-036 With MUX_NNE1_PARITY_EN, load 24'h000007 -> Paritet=1; load 24'h000003 -> Paritet=0.
